// File: rtl/ysyx_2022040010_uncache_wr_pkg.sv
// Shared AXI constants, FSM state encoding and size helpers for the uncached store path.
package ysyx_2022040010_uncache_wr_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWaitB
    } uncache_wr_state_e;

    // Mask applied to addr[2:0] so the store is naturally aligned to its size.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        logic [2:0] m;
        unique case (size)
            SIZE_B:  m = 3'b111;
            SIZE_H:  m = 3'b110;
            SIZE_W:  m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    // Lane-0 strobe pattern for a given access size.
    function automatic logic [7:0] size_strb(input logic [1:0] size);
        logic [7:0] s;
        unique case (size)
            SIZE_B:  s = 8'h01;
            SIZE_H:  s = 8'h03;
            SIZE_W:  s = 8'h0F;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ysyx_2022040010_uncache_wstrb.sv
// Lane steering for an uncached store: right-aligned store data and size become the
// byte strobes and shifted data for a 64-bit AXI W beat. The offset is aligned to the
// size first, so a misaligned request lands on the same lanes as its aligned address.
module ysyx_2022040010_uncache_wstrb
    import ysyx_2022040010_uncache_wr_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [2:0]  offset_i,
    input  logic [63:0] wdata_i,
    output logic [7:0]  strb_o,
    output logic [63:0] data_o
);

    logic [2:0] offset_aligned;

    // Shift strobe and data into the addressed byte lanes; strobe bits past lane 7 drop off.
    always_comb begin
        offset_aligned = offset_i & align_mask(size_i);
        strb_o         = size_strb(size_i) << offset_aligned;
        data_o         = wdata_i << {offset_aligned, 3'b000};
    end

endmodule

// File: rtl/ysyx_2022040010_uncache_wr.sv
// Uncached store unit: takes one LSU store, issues a single-beat AXI4 write (AW+W),
// waits for B and pulses done. One transaction outstanding at most.
// Optional feature macro: UNCACHE_WR_BRESP_CHECK_EN adds err_o, pulsed with done_o
// when the B response is not OKAY.
module ysyx_2022040010_uncache_wr
    import ysyx_2022040010_uncache_wr_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned AXI_ID = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [1:0]          req_size_i,
    output logic                done_o,
    output logic                aw_valid_o,
    input  logic                aw_ready_i,
    output logic [ADDR_W-1:0]   aw_addr_o,
    output logic [3:0]          aw_id_o,
    output logic [2:0]          aw_size_o,
    output logic                w_valid_o,
    input  logic                w_ready_i,
    output logic [DATA_W-1:0]   w_data_o,
    output logic [DATA_W/8-1:0] w_strb_o,
    output logic                w_last_o,
    input  logic                b_valid_i,
    output logic                b_ready_o,
    input  logic [1:0]          b_resp_i
`ifdef UNCACHE_WR_BRESP_CHECK_EN
    ,
    output logic                err_o
`endif
);

    uncache_wr_state_e   state_q;
    logic                aw_valid_q;
    logic                w_valid_q;
    logic                b_ready_q;
    logic                done_q;
    logic                err_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          size_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W/8-1:0] strb_q;

    logic [ADDR_W-1:0]   req_addr_aligned;
    logic [7:0]          lane_strb;
    logic [63:0]         lane_data;
    logic                aw_done;
    logic                w_done;

    ysyx_2022040010_uncache_wstrb u_wstrb (
        .size_i   (req_size_i),
        .offset_i (req_addr_i[2:0]),
        .wdata_i  (req_wdata_i),
        .strb_o   (lane_strb),
        .data_o   (lane_data)
    );

    // Aligned request address and per-channel completion (already done or finishing now).
    always_comb begin
        req_addr_aligned = {req_addr_i[ADDR_W-1:3], req_addr_i[2:0] & align_mask(req_size_i)};
        aw_done          = ~aw_valid_q | aw_ready_i;
        w_done           = ~w_valid_q | w_ready_i;
    end

    // Single FSM: latches the request, runs the AW/W/B handshakes and emits done/err.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        addr_q     <= req_addr_aligned;
                        size_q     <= {1'b0, req_size_i};
                        data_q     <= lane_data;
                        strb_q     <= lane_strb;
                        aw_valid_q <= 1'b1;
                        w_valid_q  <= 1'b1;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    // AW and W retire independently; leave only when both have.
                    if (aw_valid_q && aw_ready_i) aw_valid_q <= 1'b0;
                    if (w_valid_q && w_ready_i)   w_valid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        b_ready_q <= 1'b1;
                        state_q   <= StWaitB;
                    end
                end
                StWaitB: begin
                    if (b_valid_i) begin
                        b_ready_q <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= (b_resp_i != RESP_OKAY);
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o = (state_q == StIdle) & ~rst_i;
    assign done_o      = done_q;
    assign aw_valid_o  = aw_valid_q;
    assign aw_addr_o   = addr_q;
    assign aw_id_o     = 4'(AXI_ID);
    assign aw_size_o   = size_q;
    assign w_valid_o   = w_valid_q;
    assign w_data_o    = data_q;
    assign w_strb_o    = strb_q;
    assign w_last_o    = 1'b1;
    assign b_ready_o   = b_ready_q;

`ifdef UNCACHE_WR_BRESP_CHECK_EN
    assign err_o = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_ysyx_2022040010_uncache_wr.sv
// Directed self-checking bench for the uncached store unit.
module tb_ysyx_2022040010_uncache_wr;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;
    logic        done;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] aw_addr;
    logic [3:0]  aw_id;
    logic [2:0]  aw_size;
    logic        w_valid;
    logic        w_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic        b_valid;
    logic        b_ready;
    logic [1:0]  b_resp;
`ifdef UNCACHE_WR_BRESP_CHECK_EN
    logic        err;
`endif

    int total;
    int bad;
    int done_cnt;

    ysyx_2022040010_uncache_wr #(
        .ADDR_W (32),
        .DATA_W (64),
        .AXI_ID (0)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_size_i  (req_size),
        .done_o      (done),
        .aw_valid_o  (aw_valid),
        .aw_ready_i  (aw_ready),
        .aw_addr_o   (aw_addr),
        .aw_id_o     (aw_id),
        .aw_size_o   (aw_size),
        .w_valid_o   (w_valid),
        .w_ready_i   (w_ready),
        .w_data_o    (w_data),
        .w_strb_o    (w_strb),
        .w_last_o    (w_last),
        .b_valid_i   (b_valid),
        .b_ready_o   (b_ready),
        .b_resp_i    (b_resp)
`ifdef UNCACHE_WR_BRESP_CHECK_EN
        ,
        .err_o       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses seen at clock edges.
    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_req_ready_in_rst: got %b expected 0", req_ready);
        end
        rst = 1'b0;
        #1;
        chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
        chk("reset_valids", {61'd0, aw_valid, w_valid, b_ready}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_aw_addr", {32'd0, aw_addr}, 64'd0);
        chk("reset_w_strb", {56'd0, w_strb}, 64'd0);
        chk("reset_w_data", w_data, 64'd0);
`ifdef UNCACHE_WR_BRESP_CHECK_EN
        chk("reset_err", {63'd0, err}, 64'd0);
`endif
    endtask

    task automatic test_byte_store();
        aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; b_resp = 2'b00;
        req_valid = 1'b1; req_addr = 32'hA000_0003; req_wdata = 64'h5A; req_size = 2'd0;
        tick();
        req_valid = 1'b0; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        chk("byte_send_valids", {62'd0, aw_valid, w_valid}, 64'd3);
        chk("byte_aw_addr", {32'd0, aw_addr}, 64'hA000_0003);
        chk("byte_aw_size", {61'd0, aw_size}, 64'd0);
        chk("byte_aw_id", {60'd0, aw_id}, 64'd0);
        chk("byte_w_strb", {56'd0, w_strb}, 64'h08);
        chk("byte_w_data", w_data, 64'h0000_0000_5A00_0000);
        chk("byte_w_last", {63'd0, w_last}, 64'd1);
        chk("byte_req_ready_busy", {63'd0, req_ready}, 64'd0);
        chk("byte_b_ready_in_send", {63'd0, b_ready}, 64'd0);
        tick();
        chk("byte_waitb", {60'd0, aw_valid, w_valid, b_ready, done}, 64'b0010);
        tick();
        chk("byte_done", {61'd0, done, b_ready, req_ready}, 64'b101);
`ifdef UNCACHE_WR_BRESP_CHECK_EN
        chk("byte_err_okay", {63'd0, err}, 64'd0);
`endif
        tick();
        chk("byte_done_pulse", {63'd0, done}, 64'd0);
    endtask

    task automatic test_dword_aw_late();
        int start;
        start = done_cnt;
        aw_ready = 1'b0; w_ready = 1'b1; b_valid = 1'b0;
        req_valid = 1'b1; req_addr = 32'hA000_0008; req_wdata = 64'h1122_3344_5566_7788;
        req_size = 2'd3;
        tick();
        req_valid = 1'b0; req_addr = 32'h0;
        chk("dw_aw_addr", {32'd0, aw_addr}, 64'hA000_0008);
        chk("dw_aw_size", {61'd0, aw_size}, 64'd3);
        chk("dw_w_strb", {56'd0, w_strb}, 64'hFF);
        chk("dw_w_data", w_data, 64'h1122_3344_5566_7788);
        tick();
        chk("dw_w_first", {61'd0, aw_valid, w_valid, b_ready}, 64'b100);
        tick();
        tick();
        chk("dw_aw_held", {61'd0, aw_valid, w_valid, b_ready}, 64'b100);
        aw_ready = 1'b1;
        tick();
        chk("dw_aw_done", {61'd0, aw_valid, w_valid, b_ready}, 64'b001);
        b_valid = 1'b1;
        tick();
        chk("dw_done", {63'd0, done}, 64'd1);
        b_valid = 1'b0;
        tick();
        tick();
        chk("dw_one_done", 64'(done_cnt - start), 64'd1);
    endtask

    task automatic test_half_w_late();
        aw_ready = 1'b1; w_ready = 1'b0; b_valid = 1'b1; b_resp = 2'b00;
        req_valid = 1'b1; req_addr = 32'hA000_0007; req_wdata = 64'hBEEF; req_size = 2'd1;
        tick();
        req_valid = 1'b0;
        chk("half_aw_addr", {32'd0, aw_addr}, 64'hA000_0006);
        chk("half_w_strb", {56'd0, w_strb}, 64'hC0);
        chk("half_w_data", w_data, 64'hBEEF_0000_0000_0000);
        tick();
        chk("half_aw_first", {60'd0, aw_valid, w_valid, b_ready, done}, 64'b0100);
        w_ready = 1'b1;
        tick();
        chk("half_w_done", {61'd0, w_valid, b_ready, done}, 64'b010);
        tick();
        chk("half_done", {63'd0, done}, 64'd1);
        tick();
    endtask

    task automatic test_b_during_send();
        int start;
        start = done_cnt;
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b1; b_resp = 2'b00;
        req_valid = 1'b1; req_addr = 32'hA000_0010; req_wdata = 64'h1234_5678; req_size = 2'd2;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("bsend_still_send", {60'd0, aw_valid, w_valid, b_ready, done}, 64'b1100);
        chk("bsend_no_done", 64'(done_cnt - start), 64'd0);
        aw_ready = 1'b1; w_ready = 1'b1;
        tick();
        chk("bsend_waitb", {61'd0, aw_valid, w_valid, b_ready}, 64'b001);
        tick();
        chk("bsend_done", {63'd0, done}, 64'd1);
        b_valid = 1'b0;
        tick();
        tick();
        chk("bsend_one_done", 64'(done_cnt - start), 64'd1);
    endtask

    task automatic test_bresp_err();
        aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; b_resp = 2'b10;
        req_valid = 1'b1; req_addr = 32'hA000_0020; req_wdata = 64'h77; req_size = 2'd0;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("err_done", {63'd0, done}, 64'd1);
`ifdef UNCACHE_WR_BRESP_CHECK_EN
        chk("err_flag", {63'd0, err}, 64'd1);
`endif
        tick();
        chk("err_done_clear", {63'd0, done}, 64'd0);
`ifdef UNCACHE_WR_BRESP_CHECK_EN
        chk("err_flag_clear", {63'd0, err}, 64'd0);
`endif
        b_resp = 2'b00;
    endtask

    task automatic test_rst_mid();
        int start;
        aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b0;
        req_valid = 1'b1; req_addr = 32'hA000_0030; req_wdata = 64'h99; req_size = 2'd0;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rst_in_waitb", {63'd0, b_ready}, 64'd1);
        start = done_cnt;
        rst = 1'b1;
        tick();
        chk("rst_valids", {61'd0, aw_valid, w_valid, b_ready}, 64'd0);
        chk("rst_req_ready_held", {63'd0, req_ready}, 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        b_valid = 1'b1;
        tick();
        tick();
        chk("rst_no_done", 64'(done_cnt - start), 64'd0);
        b_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; b_resp = 2'b00;
        req_valid = 1'b1; req_addr = 32'hA000_0004; req_wdata = 64'hDEAD_BEEF; req_size = 2'd2;
        tick();
        req_addr = 32'hA000_0041; req_wdata = 64'h0102_0304_0506_0708; req_size = 2'd3;
        chk("b2b_first_addr", {32'd0, aw_addr}, 64'hA000_0004);
        chk("b2b_first_strb", {56'd0, w_strb}, 64'hF0);
        chk("b2b_first_data", w_data, 64'hDEAD_BEEF_0000_0000);
        tick();
        chk("b2b_latched_stable", {32'd0, aw_addr}, 64'hA000_0004);
        tick();
        chk("b2b_done_and_ready", {62'd0, done, req_ready}, 64'b11);
        tick();
        req_valid = 1'b0;
        chk("b2b_second_send", {61'd0, aw_valid, done, req_ready}, 64'b100);
        chk("b2b_second_addr", {32'd0, aw_addr}, 64'hA000_0040);
        chk("b2b_second_data", w_data, 64'h0102_0304_0506_0708);
        chk("b2b_second_strb", {56'd0, w_strb}, 64'hFF);
        tick();
        tick();
        chk("b2b_second_done", {63'd0, done}, 64'd1);
        tick();
        b_valid = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; done_cnt = 0;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
        test_reset();
        test_byte_store();
        test_dword_aw_late();
        test_half_w_late();
        test_b_during_send();
        test_bresp_err();
        test_rst_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
